// File: rtl/uart_pkt_pkg.sv
// Shared types and defaults for the UART packet framer.
// Holds the FSM state encoding, default sync bytes, and default payload depth.
package uart_pkt_pkg;

    localparam int         DEF_MAX_LEN = 64;
    localparam logic [7:0] DEF_HDR0    = 8'h55;
    localparam logic [7:0] DEF_HDR1    = 8'hAA;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND_H0,
        SEND_H1,
        SEND_LEN,
        SEND_PL,
        SEND_CS
    } state_e;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload store: DEPTH x 8 memory, one write port, one registered read port.
// Ports: clk_i, we_i/waddr_i/wdata_i (write), re_i/raddr_i (read), rdata_o.
module uart_pkt_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_pkt_tx.sv
// Packet framer: buffers payload bytes, then emits HDR0,HDR1,LEN,payload,CSUM.
// Ports: sys_clk/sys_rst_n; pkt_* upstream handshake; tx_* downstream
// handshake; busy, frame_done (checksum accepted), ovf (payload byte dropped).
module uart_pkt_tx
    import uart_pkt_pkg::*;
#(
    parameter int         MAX_LEN = DEF_MAX_LEN,
    parameter logic [7:0] HDR0    = DEF_HDR0,
    parameter logic [7:0] HDR1    = DEF_HDR1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] pkt_data,
    input  logic       pkt_valid,
    input  logic       pkt_last,
    output logic       pkt_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       ovf
);

    localparam int         AW   = addr_w(MAX_LEN);
    localparam logic [7:0] FULL = 8'(MAX_LEN);

    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    idx_q, idx_d;
    logic          run_q;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;

    logic          up_fire, dn_fire, full, pl_last;
    logic          wr_en, rd_en;
    logic [7:0]    idx_nxt, rd_data;
    logic [AW-1:0] rd_addr;

    // run_q keeps pkt_ready low through the reset cycle itself
    assign pkt_ready  = run_q && (state_q == IDLE || state_q == LOAD);
    assign tx_valid   = !(state_q == IDLE || state_q == LOAD);
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;
    assign ovf        = ovf_q;

    assign up_fire = pkt_valid && pkt_ready;
    assign dn_fire = tx_valid && tx_ready;
    assign full    = (cnt_q == FULL);
    assign pl_last = (idx_q == cnt_q - 8'd1);
    assign idx_nxt = idx_q + 8'd1;

    // Read port sits on entry 0 until SEND_PL, then fetches the next entry
    // on the same edge that the current one is handed off.
    assign rd_en   = (state_q != SEND_PL) || (tx_ready && !pl_last);
    assign rd_addr = (state_q == SEND_PL) ? idx_nxt[AW-1:0] : '0;

    uart_pkt_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk_i   (sys_clk),
        .we_i    (wr_en),
        .waddr_i (cnt_q[AW-1:0]),
        .wdata_i (pkt_data),
        .re_i    (rd_en),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    always_comb begin
        tx_data = 8'h00;
        unique case (state_q)
            SEND_H0:  tx_data = HDR0;
            SEND_H1:  tx_data = HDR1;
            SEND_LEN: tx_data = cnt_q;
            SEND_PL:  tx_data = rd_data;
            SEND_CS:  tx_data = cnt_q + sum_q;
            default:  tx_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        done_d  = 1'b0;
        ovf_d   = 1'b0;
        unique case (state_q)
            IDLE, LOAD: begin
                if (up_fire) begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + 8'd1;
                        sum_d = sum_q + pkt_data;
                    end
                    state_d = pkt_last ? SEND_H0 : LOAD;
                end
            end
            SEND_H0: if (dn_fire) state_d = SEND_H1;
            SEND_H1: if (dn_fire) state_d = SEND_LEN;
            SEND_LEN: begin
                if (dn_fire) begin
                    state_d = SEND_PL;
                    idx_d   = 8'd0;
                end
            end
            SEND_PL: begin
                if (dn_fire) begin
                    if (pl_last) state_d = SEND_CS;
                    else         idx_d   = idx_nxt;
                end
            end
            SEND_CS: begin
                if (dn_fire) begin
                    done_d  = 1'b1;
                    cnt_d   = 8'd0;
                    sum_d   = 8'd0;
                    idx_d   = 8'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            sum_q   <= 8'd0;
            idx_q   <= 8'd0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            run_q   <= 1'b1;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_pkt_tx.sv
// Directed bench for uart_pkt_tx: default instance plus a MAX_LEN=4 instance.
// Expected frames and checksums are hand-computed constants.
module tb_uart_pkt_tx;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [7:0] pkt_data  = 8'h00;
    logic       pkt_valid = 1'b0;
    logic       pkt_last  = 1'b0;
    logic       tx_ready  = 1'b0;

    logic       a_rdy, a_txv, a_busy, a_done, a_ovf;
    logic [7:0] a_txd;
    logic       b_rdy, b_txv, b_busy, b_done, b_ovf;
    logic [7:0] b_txd;

    always #5 sys_clk = ~sys_clk;

    uart_pkt_tx u_dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_last(pkt_last),
        .pkt_ready(a_rdy), .tx_data(a_txd), .tx_valid(a_txv),
        .tx_ready(tx_ready), .busy(a_busy), .frame_done(a_done), .ovf(a_ovf)
    );

    uart_pkt_tx #(.MAX_LEN(4)) u_dut4 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_last(pkt_last),
        .pkt_ready(b_rdy), .tx_data(b_txd), .tx_valid(b_txv),
        .tx_ready(tx_ready), .busy(b_busy), .frame_done(b_done), .ovf(b_ovf)
    );

    logic       sel = 1'b0;
    logic       o_rdy, o_txv, o_busy, o_done, o_ovf;
    logic [7:0] o_txd;

    assign o_rdy  = sel ? b_rdy  : a_rdy;
    assign o_txv  = sel ? b_txv  : a_txv;
    assign o_txd  = sel ? b_txd  : a_txd;
    assign o_busy = sel ? b_busy : a_busy;
    assign o_done = sel ? b_done : a_done;
    assign o_ovf  = sel ? b_ovf  : a_ovf;

    int checks = 0;
    int fails  = 0;
    int done_cnt = 0;
    int ovf_cnt  = 0;
    int base;
    int stab_err;
    int first_cyc, last_cyc;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    always @(posedge sys_clk) begin
        if (o_done === 1'b1) done_cnt++;
        if (o_ovf === 1'b1) ovf_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        pkt_valid = 1'b1;
        pkt_data  = d;
        pkt_last  = last;
        while (o_rdy !== 1'b1 && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        chk("send_timeout", 32'(n >= 50), 32'd0);
        @(negedge sys_clk);
        pkt_valid = 1'b0;
        pkt_last  = 1'b0;
    endtask

    task automatic collect(input int n, input logic rnd);
        int cyc;
        logic pv;
        logic [7:0] pd;
        got.delete();
        stab_err  = 0;
        first_cyc = -1;
        last_cyc  = -1;
        cyc = 0;
        pv  = 1'b0;
        pd  = 8'h00;
        while (got.size() < n && cyc < 400) begin
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pv && (o_txv !== 1'b1 || o_txd !== pd)) stab_err++;
            pv = o_txv && !tx_ready;
            pd = o_txd;
            if (o_txv && tx_ready) begin
                got.push_back(o_txd);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            cyc++;
            @(negedge sys_clk);
        end
        chk("collect_count", 32'(got.size()), 32'(n));
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("rst_tx_valid", 32'(o_txv), 32'd0);
        chk("rst_tx_data", 32'(o_txd), 32'h00);
        chk("rst_pkt_ready", 32'(o_rdy), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_frame_done", 32'(o_done), 32'd0);
        chk("rst_ovf", 32'(o_ovf), 32'd0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("ready_after_rst", 32'(o_rdy), 32'd1);

        // three-byte frame, sink always ready
        tx_ready = 1'b1;
        base = done_cnt;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b1);
        chk("a_h0_valid", 32'(o_txv), 32'd1);
        chk("a_h0_data", 32'(o_txd), 32'h55);
        chk("a_ready_low", 32'(o_rdy), 32'd0);
        chk("a_busy", 32'(o_busy), 32'd1);
        collect(7, 1'b0);
        exp_q = '{8'h55, 8'hAA, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
        check_stream("a_stream");
        chk("a_cycles", 32'(last_cyc - first_cyc + 1), 32'd7);
        @(negedge sys_clk);
        chk("a_frame_done", 32'(done_cnt - base), 32'd1);
        chk("a_idle_busy", 32'(o_busy), 32'd0);

        // single byte, checksum wraps
        send(8'hFF, 1'b1);
        collect(5, 1'b0);
        exp_q = '{8'h55, 8'hAA, 8'h01, 8'hFF, 8'h00};
        check_stream("b_stream");

        // random back-pressure
        tx_ready = 1'b0;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b1);
        collect(7, 1'b1);
        exp_q = '{8'h55, 8'hAA, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
        check_stream("c_stream");
        chk("c_stable", 32'(stab_err), 32'd0);

        // upstream held valid while sending: stalled, not lost
        tx_ready = 1'b0;
        send(8'h01, 1'b1);
        pkt_valid = 1'b1;
        pkt_data  = 8'h77;
        pkt_last  = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("d_ready_low", 32'(o_rdy), 32'd0);
        chk("d_hold_data", 32'(o_txd), 32'h55);
        collect(5, 1'b0);
        exp_q = '{8'h55, 8'hAA, 8'h01, 8'h01, 8'h02};
        check_stream("d_stream1");
        @(negedge sys_clk);
        pkt_valid = 1'b0;
        pkt_last  = 1'b0;
        collect(5, 1'b0);
        exp_q = '{8'h55, 8'hAA, 8'h01, 8'h77, 8'h78};
        check_stream("d_stream2");

        // reset during payload
        tx_ready = 1'b0;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b1);
        collect(4, 1'b0);
        tx_ready = 1'b0;
        chk("e_pl_data", 32'(o_txd), 32'h02);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        chk("e_rst_valid", 32'(o_txv), 32'd0);
        chk("e_rst_busy", 32'(o_busy), 32'd0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("e_ready", 32'(o_rdy), 32'd1);
        send(8'h05, 1'b1);
        collect(5, 1'b0);
        exp_q = '{8'h55, 8'hAA, 8'h01, 8'h05, 8'h06};
        check_stream("e_stream");

        // overflow on the MAX_LEN=4 instance
        sel = 1'b1;
        tx_ready = 1'b0;
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        base = ovf_cnt;
        for (int i = 0; i < 6; i++) begin
            send(8'(8'h10 + i), 1'(i == 5));
        end
        collect(8, 1'b0);
        exp_q = '{8'h55, 8'hAA, 8'h04, 8'h10, 8'h11, 8'h12, 8'h13, 8'h4A};
        check_stream("f_stream");
        chk("f_ovf_pulses", 32'(ovf_cnt - base), 32'd2);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
